// File: rtl/unstacker_rr_arbiter.sv
// Round-robin arbiter that shares one 128-to-32-bit unstacker between N_REQ block producers.
// The grant and source tag stay in place until the unstacker has drained all beats of the block.
module unstacker_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned SRC_W = $clog2(N_REQ),
    parameter int unsigned BEATS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 enable_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ*128-1:0] req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic                 blk_valid_o,
    input  logic                 blk_ready_i,
    output logic [127:0]         blk_data_o,
    input  logic                 beat_valid_i,
    input  logic                 beat_ready_i,
    output logic [SRC_W-1:0]     src_o,
    output logic                 src_valid_o,
    output logic                 busy_o,
    output logic [15:0]          blk_cnt_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {StIdle, StFwd, StDrain} state_e;

    state_e           state_q;
    logic [SRC_W-1:0] g_q;
    logic [SRC_W-1:0] ptr_q;
    logic [1:0]       bc_q;
    logic [15:0]      blk_cnt_q;
    logic             err_q;

    logic             pick_valid;
    logic [SRC_W-1:0] pick_idx;
    logic [31:0]      scan_idx;
    logic [31:0]      g_inc;
    logic             beat;

    // Beats only complete while enabled; a disabled cycle neither counts nor flags them.
    assign beat  = enable_i & beat_valid_i & beat_ready_i;
    assign g_inc = (32'(g_q) + 32'd1) % N_REQ;

    // First valid requester scanning ptr, ptr+1, ... ; scanned backwards so the nearest wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned off = N_REQ; off > 0; off--) begin
            scan_idx = (32'(ptr_q) + off - 32'd1) % N_REQ;
            if (req_valid_i[scan_idx[SRC_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx[SRC_W-1:0];
            end
        end
    end

    // Control FSM with grant, pointer, beat counter, block counter and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            g_q       <= '0;
            ptr_q     <= '0;
            bc_q      <= '0;
            blk_cnt_q <= '0;
            err_q     <= 1'b0;
        end else if (clr_i) begin
            state_q   <= StIdle;
            g_q       <= '0;
            ptr_q     <= '0;
            bc_q      <= '0;
            blk_cnt_q <= '0;
            err_q     <= 1'b0;
        end else if (enable_i) begin
            unique case (state_q)
                StIdle: begin
                    if (beat) err_q <= 1'b1;
                    if (pick_valid) begin
                        g_q     <= pick_idx;
                        state_q <= StFwd;
                    end
                end
                StFwd: begin
                    if (beat) err_q <= 1'b1;
                    if (blk_ready_i) begin
                        state_q <= StDrain;
                        bc_q    <= '0;
                    end
                end
                StDrain: begin
                    if (beat) begin
                        if (bc_q == 2'(BEATS - 1)) begin
                            state_q   <= StIdle;
                            bc_q      <= '0;
                            ptr_q     <= g_inc[SRC_W-1:0];
                            blk_cnt_q <= blk_cnt_q + 16'd1;
                        end else begin
                            bc_q <= bc_q + 2'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Requester accept only for the granted index while forwarding.
    always_comb begin
        req_ready_o = '0;
        if (state_q == StFwd && enable_i) req_ready_o[g_q] = blk_ready_i;
    end

    // Combinational block path; zero outside FWD so idle data never leaks downstream.
    always_comb begin
        blk_data_o = '0;
        if (state_q == StFwd) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (g_q == SRC_W'(i)) blk_data_o = req_data_i[i*128 +: 128];
            end
        end
    end

    assign blk_valid_o = (state_q == StFwd) & enable_i;
    assign src_o       = g_q;
    assign src_valid_o = (state_q != StIdle);
    assign busy_o      = (state_q != StIdle);
    assign blk_cnt_o   = blk_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_unstacker_rr_arbiter.sv
// Bench for unstacker_rr_arbiter: directed protocol scenarios plus randomized traffic checked by
// a queue-based round-robin model and a monitor that scores every block and beat.
module tb_unstacker_rr_arbiter;

    localparam int N  = 2;
    localparam int SW = 1;

    logic             clk;
    logic             rst_ni;
    logic             clr_i;
    logic             enable_i;
    logic [N-1:0]     req_valid_i;
    logic [N*128-1:0] req_data_i;
    logic [N-1:0]     req_ready_o;
    logic             blk_valid_o;
    logic             blk_ready_i;
    logic [127:0]     blk_data_o;
    logic             beat_valid_i;
    logic             beat_ready_i;
    logic [SW-1:0]    src_o;
    logic             src_valid_o;
    logic             busy_o;
    logic [15:0]      blk_cnt_o;
    logic             err_o;

    unstacker_rr_arbiter #(.N_REQ(N)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .clr_i        (clr_i),
        .enable_i     (enable_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .blk_valid_o  (blk_valid_o),
        .blk_ready_i  (blk_ready_i),
        .blk_data_o   (blk_data_o),
        .beat_valid_i (beat_valid_i),
        .beat_ready_i (beat_ready_i),
        .src_o        (src_o),
        .src_valid_o  (src_valid_o),
        .busy_o       (busy_o),
        .blk_cnt_o    (blk_cnt_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           src;
        logic [127:0] data;
    } exp_t;

    int           checks;
    int           errors;
    int           exp_cnt;
    int           mptr;
    int           phase_cnt[N];
    logic [127:0] rq[N][$];
    exp_t         exp_q[$];
    bit           mon_en;
    bit           in_blk;
    bit           cnt_pend;
    int           cur_src;
    int           beats_seen;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard side: pops the expected block on each block handshake and tracks its beats.
    task automatic monitor();
        exp_t         e;
        logic [N-1:0] onehot;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cnt_pend) begin
                    cnt_pend = 1'b0;
                    chk("blk_cnt_after_drain", blk_cnt_o, 128'(exp_cnt));
                    chk("busy_after_drain", busy_o, 0);
                end
                if (blk_valid_o && blk_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_block src=%0d", src_o);
                    end else begin
                        e = exp_q.pop_front();
                        onehot = '0;
                        onehot[e.src] = 1'b1;
                        chk("blk_src", src_o, 128'(e.src));
                        chk("blk_data", blk_data_o, e.data);
                        chk("req_ready", req_ready_o, 128'(onehot));
                        cur_src    = e.src;
                        beats_seen = 0;
                        in_blk     = 1'b1;
                    end
                end
                if (beat_valid_i && beat_ready_i && enable_i) begin
                    if (!in_blk) begin
                        checks++;
                        errors++;
                        $display("FAIL stray_beat src=%0d", src_o);
                    end else begin
                        chk("beat_src", src_o, 128'(cur_src));
                        chk("beat_src_valid", src_valid_o, 1);
                        beats_seen++;
                        if (beats_seen == 4) begin
                            in_blk   = 1'b0;
                            exp_cnt++;
                            cnt_pend = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // Reference: with requests held until accepted, each IDLE picks the nearest non-empty
    // queue from the pointer, and the pointer then moves past the winner.
    task automatic build_expect();
        int left[N];
        int k[N];
        int total;
        exp_t e;
        total = 0;
        for (int i = 0; i < N; i++) begin
            left[i] = rq[i].size();
            k[i]    = 0;
            total  += left[i];
        end
        for (int n = 0; n < total; n++) begin
            for (int off = 0; off < N; off++) begin
                int idx;
                idx = (mptr + off) % N;
                if (left[idx] > 0) begin
                    e.src  = idx;
                    e.data = rq[idx][k[idx]];
                    exp_q.push_back(e);
                    k[idx]++;
                    left[idx]--;
                    mptr = (idx + 1) % N;
                    break;
                end
            end
        end
    endtask

    // Drives requesters and a model unstacker with random backpressure and enable gaps.
    task automatic run_phase();
        int           pend;
        int           cyc;
        bit           done;
        bit           xfer;
        bit           beat;
        bit           empty;
        logic [N-1:0] rv;
        logic [N-1:0] rr;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < phase_cnt[i]; c++) rq[i].push_back(rnd128());
        end
        build_expect();
        pend   = 0;
        cyc    = 0;
        done   = 1'b0;
        mon_en = 1'b1;
        while (!done) begin
            @(negedge clk);
            xfer = blk_valid_o & blk_ready_i;
            beat = beat_valid_i & beat_ready_i & enable_i;
            rv   = req_valid_i;
            rr   = req_ready_o;
            @(posedge clk);
            #1;
            if (xfer) pend = 4;
            if (beat && pend > 0) pend--;
            for (int i = 0; i < N; i++) begin
                if (rv[i] && rr[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            end
            empty = 1'b1;
            for (int i = 0; i < N; i++) begin
                req_valid_i[i]            = (rq[i].size() > 0);
                req_data_i[i*128 +: 128]  = (rq[i].size() > 0) ? rq[i][0] : 128'h0;
                if (rq[i].size() > 0) empty = 1'b0;
            end
            enable_i     = ($urandom_range(0, 9) != 0);
            blk_ready_i  = ($urandom_range(0, 2) != 0);
            beat_valid_i = (pend > 0) && ($urandom_range(0, 3) != 0);
            beat_ready_i = ($urandom_range(0, 3) != 0);
            cyc++;
            if (empty && pend == 0 && exp_q.size() == 0 && !in_blk) done = 1'b1;
            if (cyc > 4000) begin
                checks++;
                errors++;
                $display("FAIL phase_timeout cycles=%0d pending=%0d", cyc, exp_q.size());
                done = 1'b1;
            end
        end
        req_valid_i  = '0;
        req_data_i   = '0;
        beat_valid_i = 1'b0;
        enable_i     = 1'b1;
        tick();
        tick();
        mon_en = 1'b0;
        chk("phase_err", err_o, 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) rq[i].delete();
    endtask

    // One complete block from a single requester with all readies high.
    task automatic do_block(input int r, input logic [127:0] d);
        logic [N-1:0] onehot;
        onehot        = '0;
        onehot[r]     = 1'b1;
        enable_i      = 1'b1;
        blk_ready_i   = 1'b1;
        beat_ready_i  = 1'b1;
        beat_valid_i  = 1'b0;
        req_valid_i   = onehot;
        req_data_i    = '0;
        req_data_i[r*128 +: 128] = d;
        #1;
        chk("idle_before_grant", blk_valid_o, 0);
        tick();
        chk("grant_valid", blk_valid_o, 1);
        chk("grant_src", src_o, 128'(r));
        chk("grant_src_valid", src_valid_o, 1);
        chk("grant_data", blk_data_o, d);
        chk("grant_req_ready", req_ready_o, 128'(onehot));
        tick();
        chk("drain_blk_valid", blk_valid_o, 0);
        chk("drain_blk_data", blk_data_o, 0);
        req_valid_i  = '0;
        req_data_i   = '0;
        beat_valid_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tick();
            if (b < 3) chk("drain_src", src_o, 128'(r));
        end
        beat_valid_i = 1'b0;
        exp_cnt++;
        chk("block_done_busy", busy_o, 0);
        chk("block_done_cnt", blk_cnt_o, 128'(exp_cnt));
        chk("block_done_src_valid", src_valid_o, 0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        exp_cnt      = 0;
        mptr         = 0;
        mon_en       = 1'b0;
        in_blk       = 1'b0;
        cnt_pend     = 1'b0;
        cur_src      = 0;
        beats_seen   = 0;
        rst_ni       = 1'b0;
        clr_i        = 1'b0;
        enable_i     = 1'b1;
        req_valid_i  = '0;
        req_data_i   = '0;
        blk_ready_i  = 1'b0;
        beat_valid_i = 1'b0;
        beat_ready_i = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        chk("rst_blk_valid", blk_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_blk_data", blk_data_o, 0);
        chk("rst_src", src_o, 0);
        chk("rst_src_valid", src_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_blk_cnt", blk_cnt_o, 0);
        chk("rst_err", err_o, 0);

        // Single requester, known block.
        do_block(0, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // Backpressure in FWD, toggling beat_ready, enable gap at bc=2.
        req_valid_i = 2'b01;
        req_data_i  = '0;
        req_data_i[127:0] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        blk_ready_i = 1'b0;
        tick();
        chk("bp_src", src_o, 0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_blk_valid", blk_valid_o, 1);
            chk("bp_req_ready", req_ready_o, 0);
            tick();
        end
        chk("bp_still_fwd", blk_valid_o, 1);
        chk("bp_data", blk_data_o, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        blk_ready_i = 1'b1;
        #1;
        chk("bp_req_ready_go", req_ready_o, 2'b01);
        tick();
        req_valid_i  = '0;
        req_data_i   = '0;
        chk("bp_drain_valid", blk_valid_o, 0);
        beat_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            beat_ready_i = (c % 2 == 0);
            tick();
        end
        chk("toggle_busy", busy_o, 1);
        enable_i     = 1'b0;
        beat_ready_i = 1'b1;
        repeat (5) tick();
        chk("dis_busy", busy_o, 1);
        chk("dis_src_valid", src_valid_o, 1);
        chk("dis_cnt", blk_cnt_o, 128'(exp_cnt));
        chk("dis_err", err_o, 0);
        enable_i = 1'b1;
        tick();
        chk("reen_third_beat_busy", busy_o, 1);
        tick();
        beat_valid_i = 1'b0;
        exp_cnt++;
        chk("reen_fourth_beat_busy", busy_o, 0);
        chk("reen_cnt", blk_cnt_o, 128'(exp_cnt));

        // Beat handshake in IDLE is flagged and ignored.
        beat_valid_i = 1'b1;
        beat_ready_i = 1'b1;
        tick();
        beat_valid_i = 1'b0;
        chk("err_set", err_o, 1);
        chk("err_idle_busy", busy_o, 0);
        do_block(1, 128'h11111111_22222222_33333333_44444444);
        chk("err_sticky", err_o, 1);
        chk("src_hold", src_o, 1);
        do_block(0, 128'h55555555_66666666_77777777_88888888);

        // Clear mid-FWD while disabled; pointer was 1 so grant went to 1 before clearing.
        req_valid_i = 2'b11;
        req_data_i  = {128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004,
                       128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004};
        blk_ready_i = 1'b0;
        tick();
        chk("pre_clr_src", src_o, 1);
        clr_i    = 1'b1;
        enable_i = 1'b0;
        tick();
        clr_i    = 1'b0;
        enable_i = 1'b1;
        exp_cnt  = 0;
        chk("clr_busy", busy_o, 0);
        chk("clr_blk_valid", blk_valid_o, 0);
        chk("clr_cnt", blk_cnt_o, 0);
        chk("clr_err", err_o, 0);
        chk("clr_src", src_o, 0);
        tick();
        chk("clr_ptr_grant", src_o, 0);
        chk("clr_ptr_data", blk_data_o, 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004);
        blk_ready_i = 1'b1;
        tick();
        req_valid_i  = '0;
        req_data_i   = '0;
        beat_valid_i = 1'b1;
        repeat (4) tick();
        beat_valid_i = 1'b0;
        exp_cnt++;
        chk("clr_block_cnt", blk_cnt_o, 128'(exp_cnt));

        // Asynchronous reset in DRAIN.
        req_valid_i = 2'b01;
        req_data_i[127:0] = 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F;
        tick();
        tick();
        req_valid_i  = '0;
        req_data_i   = '0;
        beat_valid_i = 1'b1;
        tick();
        beat_valid_i = 1'b0;
        chk("pre_rst_busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        exp_cnt = 0;
        chk("arst_busy", busy_o, 0);
        chk("arst_src_valid", src_valid_o, 0);
        chk("arst_blk_valid", blk_valid_o, 0);
        chk("arst_src", src_o, 0);
        chk("arst_cnt", blk_cnt_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        do_block(1, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);

        // Randomized traffic; DUT pointer is 0 after the last block from requester 1.
        mptr = 0;
        phase_cnt[0] = 8;
        phase_cnt[1] = 8;
        run_phase();
        for (int p = 0; p < 5; p++) begin
            phase_cnt[0] = $urandom_range(0, 4);
            phase_cnt[1] = $urandom_range(0, 4);
            run_phase();
        end
        chk("final_cnt", blk_cnt_o, 128'(exp_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
